// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor setpoint path.
// Covers setpoint typing, sequencer states, target clamping and slew stepping.
package motor_pkg;

    typedef logic signed [7:0] setpoint_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RAMP  = 3'd1,
        DWELL = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } seq_state_t;

    localparam int SETPOINT_MAX = 127;

    // -128 has no positive mirror; folding it to -127 keeps all step arithmetic symmetric.
    function automatic setpoint_t clamp_target(input setpoint_t t);
        setpoint_t lim;
        lim = setpoint_t'(SETPOINT_MAX);
        return (t < -lim) ? -lim : t;
    endfunction

    function automatic setpoint_t goal_of(input setpoint_t sp, input setpoint_t tgt);
        if ((sp != 8'sd0) && (tgt[7] != sp[7])) begin
            return 8'sd0;
        end else begin
            return tgt;
        end
    endfunction

    function automatic setpoint_t step_toward(input setpoint_t sp, input setpoint_t goal,
                                              input logic [6:0] step);
        logic signed [8:0] diff_s;
        logic signed [8:0] step_s;
        logic signed [8:0] next_s;
        diff_s = $signed({goal[7], goal}) - $signed({sp[7], sp});
        step_s = $signed({2'b00, step});
        if (diff_s > step_s) begin
            next_s = $signed({sp[7], sp}) + step_s;
        end else if (diff_s < -step_s) begin
            next_s = $signed({sp[7], sp}) - step_s;
        end else begin
            next_s = $signed({goal[7], goal});
        end
        return next_s[7:0];
    endfunction

endpackage

// File: rtl/motor_tick_gen.sv
// Free-running prescaler producing a registered one-cycle tick every TICK_DIV clocks.
module motor_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             tick_r;

    // Wrapping prescaler increment.
    always_comb begin
        cnt_next_s = cnt_r;
        if (cnt_r == CNT_LAST) begin
            cnt_next_s = '0;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Tick is registered so it is high exactly while the counter sits at its last value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            tick_r <= (cnt_next_s == CNT_LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/motor_setpoint_sequencer.sv
// Slew-limited setpoint sequencer with zero-crossing dwell, estop, watchdog and latched fault.
module motor_setpoint_sequencer
    import motor_pkg::*;
#(
    parameter int TICK_DIV   = 1000,
    parameter int STEP       = 4,
    parameter int REV_DWELL  = 50,
    parameter int WDOG_TICKS = 2000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic signed [7:0] cmd_target,
    input  logic              estop,
    input  logic              fault_clr,
    output logic signed [7:0] setpoint,
    output logic              busy,
    output logic              at_target,
    output logic              fault
);

    localparam int DW_W = (REV_DWELL > 1) ? $clog2(REV_DWELL) : 1;
    localparam int WD_W = (WDOG_TICKS > 1) ? $clog2(WDOG_TICKS + 1) : 1;
    localparam logic [6:0]      STEP_C     = 7'(STEP);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(REV_DWELL - 1);
    localparam logic [WD_W-1:0] WDOG_LAST  = WD_W'(WDOG_TICKS - 1);
    localparam logic [WD_W-1:0] WDOG_TOP   = WD_W'(WDOG_TICKS);
    localparam logic            WDOG_EN    = (WDOG_TICKS > 0);

    seq_state_t      state_r, state_n;
    setpoint_t       setpoint_r, sp_n;
    setpoint_t       target_r, tgt_n;
    logic [DW_W-1:0] dwell_r, dwell_n;
    logic [WD_W-1:0] wdog_r, wdog_n;
    logic            cmd_ready_r, busy_r, at_target_r, fault_r;

    logic      tick_s, accept_s, active_s, wdog_exp_s;
    setpoint_t new_tgt_s, goal_s, step_s;

    motor_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick_s)
    );

    // Next-state logic; branch order encodes estop > wdog > fault hold > cmd accept > tick step.
    always_comb begin
        state_n    = state_r;
        sp_n       = setpoint_r;
        tgt_n      = target_r;
        dwell_n    = dwell_r;
        wdog_n     = wdog_r;
        accept_s   = cmd_valid && cmd_ready_r;
        new_tgt_s  = clamp_target(cmd_target);
        goal_s     = goal_of(setpoint_r, target_r);
        step_s     = step_toward(setpoint_r, goal_s, STEP_C);
        active_s   = (state_r == RAMP) || (state_r == DWELL) || (state_r == HOLD);
        wdog_exp_s = WDOG_EN && tick_s && active_s && (wdog_r == WDOG_LAST);

        if (estop || wdog_exp_s) begin
            state_n = FAULT;
            sp_n    = 8'sd0;
            tgt_n   = 8'sd0;
            dwell_n = '0;
        end else if (state_r == FAULT) begin
            sp_n  = 8'sd0;
            tgt_n = 8'sd0;
            if (fault_clr) begin
                state_n = IDLE;
            end else begin
                state_n = FAULT;
            end
        end else if (accept_s) begin
            tgt_n  = new_tgt_s;
            wdog_n = '0;
            case (state_r)
                IDLE:    state_n = (new_tgt_s != 8'sd0) ? RAMP : IDLE;
                HOLD:    state_n = (new_tgt_s != target_r) ? RAMP : HOLD;
                DWELL: begin
                    if (new_tgt_s == 8'sd0) begin
                        state_n = IDLE;
                        dwell_n = '0;
                    end else begin
                        state_n = DWELL;
                    end
                end
                default: state_n = state_r;
            endcase
        end else if (tick_s) begin
            if (active_s && (wdog_r != WDOG_TOP)) begin
                wdog_n = wdog_r + WD_W'(1);
            end else begin
                wdog_n = wdog_r;
            end
            case (state_r)
                RAMP: begin
                    sp_n = step_s;
                    if (step_s == target_r) begin
                        state_n = (target_r == 8'sd0) ? IDLE : HOLD;
                    end else if ((step_s == 8'sd0) && (REV_DWELL > 0)) begin
                        state_n = DWELL;
                        dwell_n = '0;
                    end else begin
                        state_n = RAMP;
                    end
                end
                DWELL: begin
                    if (dwell_r == DWELL_LAST) begin
                        state_n = RAMP;
                        dwell_n = '0;
                    end else begin
                        dwell_n = dwell_r + DW_W'(1);
                    end
                end
                default: state_n = state_r;
            endcase
        end else begin
            state_n = state_r;
        end

        if ((state_n == IDLE) || (state_n == FAULT)) begin
            wdog_n = '0;
        end else begin
            wdog_n = wdog_n;
        end
    end

    // State and registered outputs; outputs are derived from next-state values to stay aligned.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            setpoint_r  <= 8'sd0;
            target_r    <= 8'sd0;
            dwell_r     <= '0;
            wdog_r      <= '0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            at_target_r <= 1'b1;
            fault_r     <= 1'b0;
        end else begin
            state_r     <= state_n;
            setpoint_r  <= sp_n;
            target_r    <= tgt_n;
            dwell_r     <= dwell_n;
            wdog_r      <= wdog_n;
            cmd_ready_r <= (state_n != FAULT);
            busy_r      <= (state_n == RAMP) || (state_n == DWELL);
            at_target_r <= (sp_n == tgt_n) && ((state_n == IDLE) || (state_n == HOLD));
            fault_r     <= (state_n == FAULT);
        end
    end

    assign setpoint  = setpoint_r;
    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign at_target = at_target_r;
    assign fault     = fault_r;

endmodule
